// File: rtl/key_enc_pkg.sv
// Shared types and helpers for the debounced key encoder.
// f_popcnt_gt1 is only referenced when KEY_ENC_MULTI_DET_EN is defined.
package key_enc_pkg;

  // Helpers operate on a fixed-width vector; callers zero-extend their key bus.
  localparam int KEY_MAX  = 64;
  localparam int CODE_MAX = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  // Index of the highest set bit; 0 for an all-zero vector.
  function automatic logic [CODE_MAX-1:0] f_prio_enc(input logic [KEY_MAX-1:0] v);
    logic [CODE_MAX-1:0] code;
    code = '0;
    for (int i = 0; i < KEY_MAX; i++) begin
      if (v[i]) begin
        code = i[CODE_MAX-1:0];
      end
    end
    return code;
  endfunction

  function automatic logic f_popcnt_gt1(input logic [KEY_MAX-1:0] v);
    logic [KEY_MAX-1:0] one;
    one = KEY_MAX'(1);
    return (v & (v - one)) != '0;
  endfunction

endpackage

// File: rtl/key_sync2.sv
// Two-flop synchroniser for a bus of independent asynchronous levels.
module key_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_r;

  // Two-stage capture, both stages cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= '0;
      q    <= '0;
    end else begin
      s1_r <= d;
      q    <= s1_r;
    end
  end

endmodule

// File: rtl/key_encoder_db.sv
// Synchronised, priority-encoded and press/release-debounced keypad encoder.
// Define KEY_ENC_MULTI_DET_EN to add multi_key and reject multi-key chords.
module key_encoder_db
  import key_enc_pkg::*;
#(
  parameter int NUM_KEYS  = 10,
  parameter int CODE_W    = 4,
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_press,
  output logic                key_release
`ifdef KEY_ENC_MULTI_DET_EN
  ,
  output logic                multi_key
`endif
);

  logic [NUM_KEYS-1:0] s2_s;
  logic                any_s;
  logic [CODE_W-1:0]   cand_s;
  logic                last_s;
  logic                pend_ok_s;
  logic                hold_ok_s;

  state_t              state_r, state_nx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nx_s, cnt_inc_s;
  logic [CODE_W-1:0]   pend_r, pend_nx_s;
  logic [CODE_W-1:0]   code_nx_s;
  logic                valid_nx_s, press_nx_s, release_nx_s;

  key_sync2 #(.W(NUM_KEYS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (s2_s)
  );

  assign cand_s = CODE_W'(f_prio_enc(KEY_MAX'(s2_s)));

`ifdef KEY_ENC_MULTI_DET_EN
  logic multi_s;
  assign multi_s = f_popcnt_gt1(KEY_MAX'(s2_s));
  // A chord looks like "no key" to the FSM so it can never be accepted.
  assign any_s   = (|s2_s) & ~multi_s;

  // Registered chord indicator.
  always_ff @(posedge clk) begin
    if (rst) begin
      multi_key <= 1'b0;
    end else begin
      multi_key <= multi_s;
    end
  end
`else
  assign any_s = |s2_s;
`endif

  assign last_s    = (cnt_r == CNT_W'(DB_CYCLES - 1));
  assign pend_ok_s = any_s && (cand_s == pend_r);
  assign hold_ok_s = any_s && (cand_s == key_code);
  assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);

  // State, counter, pending code and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      pend_r      <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      pend_r      <= pend_nx_s;
      key_code    <= code_nx_s;
      key_valid   <= valid_nx_s;
      key_press   <= press_nx_s;
      key_release <= release_nx_s;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_s) state_nx_s = DB_PRESS;
        else       state_nx_s = IDLE;
      end
      DB_PRESS: begin
        if (!pend_ok_s)  state_nx_s = IDLE;
        else if (last_s) state_nx_s = HELD;
        else             state_nx_s = DB_PRESS;
      end
      HELD: begin
        if (!hold_ok_s) state_nx_s = DB_RELEASE;
        else            state_nx_s = HELD;
      end
      DB_RELEASE: begin
        if (hold_ok_s)   state_nx_s = HELD;
        else if (last_s) state_nx_s = IDLE;
        else             state_nx_s = DB_RELEASE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath and output next values; pulses default low every cycle.
  always_comb begin
    cnt_nx_s     = cnt_r;
    pend_nx_s    = pend_r;
    code_nx_s    = key_code;
    valid_nx_s   = key_valid;
    press_nx_s   = 1'b0;
    release_nx_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          pend_nx_s = cand_s;
          cnt_nx_s  = '0;
        end else begin
          cnt_nx_s  = cnt_r;
        end
      end
      DB_PRESS: begin
        if (!pend_ok_s) begin
          cnt_nx_s   = cnt_r;
        end else if (last_s) begin
          code_nx_s  = pend_r;
          valid_nx_s = 1'b1;
          press_nx_s = 1'b1;
        end else begin
          cnt_nx_s   = cnt_inc_s;
        end
      end
      HELD: begin
        if (!hold_ok_s) cnt_nx_s = '0;
        else            cnt_nx_s = cnt_r;
      end
      DB_RELEASE: begin
        if (hold_ok_s) begin
          cnt_nx_s     = cnt_r;
        end else if (last_s) begin
          code_nx_s    = '0;
          valid_nx_s   = 1'b0;
          release_nx_s = 1'b1;
        end else begin
          cnt_nx_s     = cnt_inc_s;
        end
      end
      default: begin
        cnt_nx_s = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_encoder_db.sv
// Directed self-checking bench for key_encoder_db (NUM_KEYS=10, CODE_W=4, DB_CYCLES=4).
// Also builds with KEY_ENC_MULTI_DET_EN defined.
module tb_key_encoder_db;

  localparam int NK = 10;
  localparam int CW = 4;
  localparam int DB = 4;
`ifdef KEY_ENC_MULTI_DET_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [NK-1:0] key_in;
  logic [CW-1:0] key_code;
  logic          key_valid, key_press, key_release;
`ifdef KEY_ENC_MULTI_DET_EN
  logic          multi_key;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int press_seen   = 0;
  int release_seen = 0;
  int both_seen    = 0;

  key_encoder_db #(.NUM_KEYS(NK), .CODE_W(CW), .DB_CYCLES(DB), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_press   (key_press),
    .key_release (key_release)
`ifdef KEY_ENC_MULTI_DET_EN
    ,
    .multi_key   (multi_key)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_press)               press_seen++;
    if (key_release)             release_seen++;
    if (key_press && key_release) both_seen++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    key_in = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_in = 10'h3FF;
    tick(3);
    total_cnt++;
    if ({key_code, key_valid, key_press, key_release} !== 7'd0) begin
      $display("FAIL reset_outputs: got code=%0d v=%b p=%b r=%b want all 0",
               key_code, key_valid, key_press, key_release);
    end else pass_cnt++;
    rst = 1'b0;
    tick(DB + 2);
    total_cnt++;
    if (key_valid !== 1'b0) $display("FAIL reset_early_valid: got %b want 0", key_valid);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (key_valid !== !MULTI || key_code !== (MULTI ? 4'd0 : 4'd9)) begin
      $display("FAIL reset_first_key: got v=%b code=%0d want v=%b code=%0d",
               key_valid, key_code, !MULTI, MULTI ? 0 : 9);
    end else pass_cnt++;
  endtask

  task automatic test_press_release();
    int p0, r0;
    reset_dut();
    p0 = press_seen; r0 = release_seen;
    key_in = 10'b00_0010_0000;
    tick(6);
    total_cnt++;
    if (key_valid !== 1'b0 || key_press !== 1'b0)
      $display("FAIL press_early: got v=%b p=%b want 0 0", key_valid, key_press);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (key_press !== 1'b1 || key_valid !== 1'b1 || key_code !== 4'd5)
      $display("FAIL press_edge7: got p=%b v=%b code=%0d want 1 1 5", key_press, key_valid, key_code);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (key_press !== 1'b0 || key_valid !== 1'b1 || key_code !== 4'd5)
      $display("FAIL press_one_cycle: got p=%b v=%b code=%0d want 0 1 5", key_press, key_valid, key_code);
    else pass_cnt++;
    tick(12);
    key_in = '0;
    tick(6);
    total_cnt++;
    if (key_release !== 1'b0 || key_valid !== 1'b1)
      $display("FAIL release_early: got r=%b v=%b want 0 1", key_release, key_valid);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (key_release !== 1'b1 || key_valid !== 1'b0 || key_code !== 4'd0)
      $display("FAIL release_edge27: got r=%b v=%b code=%0d want 1 0 0", key_release, key_valid, key_code);
    else pass_cnt++;
    tick(2);
    total_cnt++;
    if (press_seen - p0 !== 1 || release_seen - r0 !== 1)
      $display("FAIL press_release_counts: got p=%0d r=%0d want 1 1", press_seen - p0, release_seen - r0);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    int p0, r0;
    reset_dut();
    p0 = press_seen; r0 = release_seen;
    for (int i = 0; i < 8; i++) begin
      key_in = (i % 2 == 0) ? 10'h008 : 10'h000;
      tick(1);
    end
    key_in = 10'h008;
    tick(6);
    total_cnt++;
    if (press_seen - p0 !== 0 || release_seen - r0 !== 0 || key_valid !== 1'b0)
      $display("FAIL bounce_no_pulse: got p=%0d r=%0d v=%b want 0 0 0",
               press_seen - p0, release_seen - r0, key_valid);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (key_press !== 1'b1 || key_code !== 4'd3)
      $display("FAIL bounce_press: got p=%b code=%0d want 1 3", key_press, key_code);
    else pass_cnt++;
  endtask

  task automatic test_release_bounce();
    int r0;
    bit dropped;
    reset_dut();
    key_in = 10'h080;
    tick(8);
    total_cnt++;
    if (key_valid !== 1'b1 || key_code !== 4'd7)
      $display("FAIL rb_held: got v=%b code=%0d want 1 7", key_valid, key_code);
    else pass_cnt++;
    r0 = release_seen;
    dropped = 1'b0;
    key_in = '0;
    tick(2);
    key_in = 10'h080;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (key_valid !== 1'b1 || key_code !== 4'd7) dropped = 1'b1;
    end
    total_cnt++;
    if (release_seen - r0 !== 0 || dropped)
      $display("FAIL rb_absorbed: got releases=%0d valid_drop=%b want 0 0", release_seen - r0, dropped);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    reset_dut();
    key_in = 10'h104;
`ifdef KEY_ENC_MULTI_DET_EN
    tick(3);
    total_cnt++;
    if (multi_key !== 1'b1) $display("FAIL chord_multi: got %b want 1", multi_key);
    else pass_cnt++;
    tick(4);
    total_cnt++;
    if (key_valid !== 1'b0) $display("FAIL chord_rejected: got v=%b want 0", key_valid);
    else pass_cnt++;
`else
    tick(7);
    total_cnt++;
    if (key_valid !== 1'b1 || key_code !== 4'd8)
      $display("FAIL prio_highest: got v=%b code=%0d want 1 8", key_valid, key_code);
    else pass_cnt++;
`endif
    key_in = 10'h100;
    tick(DB + 3);
    total_cnt++;
    if (key_valid !== 1'b1 || key_code !== 4'd8)
      $display("FAIL prio_single8: got v=%b code=%0d want 1 8", key_valid, key_code);
    else pass_cnt++;
`ifdef KEY_ENC_MULTI_DET_EN
    total_cnt++;
    if (multi_key !== 1'b0) $display("FAIL chord_multi_clear: got %b want 0", multi_key);
    else pass_cnt++;
`endif
  endtask

  task automatic test_key_change();
    reset_dut();
    key_in = 10'h002;
    tick(8);
    key_in = 10'h040;
    tick(6);
    total_cnt++;
    if (key_release !== 1'b0 || key_code !== 4'd1)
      $display("FAIL change_hold_a: got r=%b code=%0d want 0 1", key_release, key_code);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (key_release !== 1'b1 || key_valid !== 1'b0 || key_code !== 4'd0)
      $display("FAIL change_release_a: got r=%b v=%b code=%0d want 1 0 0", key_release, key_valid, key_code);
    else pass_cnt++;
    tick(DB);
    total_cnt++;
    if (key_press !== 1'b0) $display("FAIL change_press_early: got %b want 0", key_press);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (key_press !== 1'b1 || key_code !== 4'd6)
      $display("FAIL change_press_b: got p=%b code=%0d want 1 6", key_press, key_code);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_hold();
    int r0;
    reset_dut();
    key_in = 10'h010;
    tick(8);
    r0 = release_seen;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    total_cnt++;
    if ({key_code, key_valid, key_press, key_release} !== 7'd0)
      $display("FAIL midrst_outputs: got code=%0d v=%b p=%b r=%b want all 0",
               key_code, key_valid, key_press, key_release);
    else pass_cnt++;
    tick(DB + 2);
    total_cnt++;
    if (key_press !== 1'b0) $display("FAIL midrst_press_early: got %b want 0", key_press);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (key_press !== 1'b1 || key_code !== 4'd4 || release_seen - r0 !== 0)
      $display("FAIL midrst_repress: got p=%b code=%0d rel=%0d want 1 4 0",
               key_press, key_code, release_seen - r0);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    key_in = '0;
    test_reset();
    test_press_release();
    test_bounce();
    test_release_bounce();
    test_priority();
    test_key_change();
    test_reset_mid_hold();
    total_cnt++;
    if (both_seen !== 0) $display("FAIL press_and_release_same_cycle: got %0d want 0", both_seen);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
